// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller: FSM encoding and the word
// returned to the core on decode or timeout errors.
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_t;

    localparam logic [31:0] BUS_ERR_WORD = 32'hDEADBEEF;

    // Error word sized to the data bus (truncated or zero-extended).
    function automatic logic [63:0] err_word_ext();
        return {32'd0, BUS_ERR_WORD};
    endfunction

endpackage

// File: rtl/mem_bus_controller_decoder.sv
// Combinational slave decoder: maps the upper address field to a slave index,
// a validity flag and a one-hot chip select.
module bus_addr_decoder
    import bus_ctrl_pkg::*;
#(
    parameter int N_SLAVES = 2,
    parameter int SEL_W    = 1
) (
    input  logic [SEL_W-1:0]    sel_field,
    output logic [SEL_W-1:0]    index,
    output logic                valid,
    output logic [N_SLAVES-1:0] cs
);

    always_comb begin
        index = sel_field;
        valid = (32'(sel_field) < 32'(N_SLAVES));
        cs    = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            cs[i] = (sel_field == SEL_W'(i));
        end
    end

endmodule

// File: rtl/mem_bus_controller.sv
// Core data-port to N_SLAVES bus controller: decode, one-hot chip select, wait states,
// registered read data. Optional access timeout enabled by defining BUS_TIMEOUT_EN.
module mem_bus_controller
    import bus_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int N_SLAVES    = 2,
    parameter int SEL_W       = 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [ADDR_W-1:0]          cpu_addr,
    input  logic [DATA_W-1:0]          cpu_wdata,
    output logic [DATA_W-1:0]          cpu_rdata,
    output logic                       cpu_ready,
    output logic                       cpu_err,
    output logic [N_SLAVES-1:0]        slv_cs,
    output logic                       slv_we,
    output logic [ADDR_W-1:0]          slv_addr,
    output logic [DATA_W-1:0]          slv_wdata,
    input  logic [N_SLAVES*DATA_W-1:0] slv_rdata,
    input  logic [N_SLAVES-1:0]        slv_ready
);

    localparam logic [63:0]       ERR_WORD_64 = err_word_ext();
    localparam logic [DATA_W-1:0] ERR_WORD    = ERR_WORD_64[DATA_W-1:0];

    bus_state_t state;
    bus_state_t state_next;

    logic                we_q;
    logic [SEL_W-1:0]    idx_q;
    logic [N_SLAVES-1:0] cs_q;

    logic [SEL_W-1:0]    dec_index;
    logic                dec_valid;
    logic [N_SLAVES-1:0] dec_cs;

    logic                ready_sel;
    logic [DATA_W-1:0]   rdata_sel;
    logic                timeout;

    bus_addr_decoder #(
        .N_SLAVES (N_SLAVES),
        .SEL_W    (SEL_W)
    ) u_decoder (
        .sel_field (cpu_addr[ADDR_W-1 -: SEL_W]),
        .index     (dec_index),
        .valid     (dec_valid),
        .cs        (dec_cs)
    );

    // Only the latched slave's ready and read data are observed.
    always_comb begin
        ready_sel = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                ready_sel = slv_ready[i];
                rdata_sel = slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] wait_cnt;

    // Counts ACCESS cycles without ready; held at zero outside ACCESS so each
    // access starts from a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != ST_ACCESS) begin
            wait_cnt <= '0;
        end else if (!ready_sel) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Ready arriving in the expiry cycle takes priority over the timeout.
    assign timeout = (state == ST_ACCESS) && !ready_sel
                     && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_next = dec_valid ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (ready_sel || timeout) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = (state == ST_RESP);
        slv_cs    = (state == ST_ACCESS) ? cs_q : '0;
        slv_we    = (state == ST_ACCESS) && we_q;
    end

    // Request latches and response registers; cpu_rdata only moves on read
    // completions and error responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            idx_q     <= '0;
            cs_q      <= '0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        we_q      <= cpu_we;
                        idx_q     <= dec_index;
                        cs_q      <= dec_cs;
                        slv_addr  <= cpu_addr;
                        slv_wdata <= cpu_wdata;
                        if (!dec_valid) begin
                            cpu_err   <= 1'b1;
                            cpu_rdata <= ERR_WORD;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (ready_sel) begin
                        cpu_err <= 1'b0;
                        if (!we_q) begin
                            cpu_rdata <= rdata_sel;
                        end
                    end else if (timeout) begin
                        cpu_err   <= 1'b1;
                        cpu_rdata <= ERR_WORD;
                    end
                end
                ST_RESP: begin
                    cpu_err <= 1'b0;
                end
                default: begin
                    cpu_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_controller.sv
// Bench for mem_bus_controller: a 2-slave and a 3-slave instance sharing one core-side
// driver; expected responses are queued by the driver and checked by a separate monitor.
module tb_mem_bus_controller;
    import bus_ctrl_pkg::*;

    localparam int TIMEOUT_CYC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req, use_b, we;
    logic [31:0] addr, wdata;
    logic        req_a, req_b;
    assign req_a = req & ~use_b;
    assign req_b = req & use_b;

    logic [31:0] a_rdata, a_addr, a_wdata;
    logic        a_ready, a_err, a_we;
    logic [1:0]  a_cs, a_sready;
    logic [63:0] a_srdata;

    logic [31:0] b_rdata, b_addr, b_wdata;
    logic        b_ready, b_err, b_we;
    logic [2:0]  b_cs, b_sready;
    logic [95:0] b_srdata;

    mem_bus_controller #(
        .DATA_W(32), .ADDR_W(32), .N_SLAVES(2), .SEL_W(1), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .cpu_req(req_a), .cpu_we(we), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_rdata(a_rdata), .cpu_ready(a_ready), .cpu_err(a_err),
        .slv_cs(a_cs), .slv_we(a_we), .slv_addr(a_addr), .slv_wdata(a_wdata),
        .slv_rdata(a_srdata), .slv_ready(a_sready)
    );

    mem_bus_controller #(
        .DATA_W(32), .ADDR_W(32), .N_SLAVES(3), .SEL_W(2), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .cpu_req(req_b), .cpu_we(we), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_rdata(b_rdata), .cpu_ready(b_ready), .cpu_err(b_err),
        .slv_cs(b_cs), .slv_we(b_we), .slv_addr(b_addr), .slv_wdata(b_wdata),
        .slv_rdata(b_srdata), .slv_ready(b_sready)
    );

    typedef struct packed {
        logic        dut;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_a = 32'd0;
    logic [31:0] last_b = 32'd0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && (a_ready || b_ready)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got a=%b b=%b expected no response (cycle %0d)",
                         a_ready, b_ready, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_dut", {31'd0, b_ready}, {31'd0, mon_e.dut});
                chk("resp_cycle", 32'(cyc), mon_e.cyc);
                chk("resp_err", {31'd0, (mon_e.dut ? b_err : a_err)}, {31'd0, mon_e.err});
                chk("resp_rdata", mon_e.dut ? b_rdata : a_rdata, mon_e.rdata);
            end
        end
    end

    // One core transaction; entered and left at posedge+1 with the DUT in IDLE.
    task automatic txn(input logic b, input logic w, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] rd, input int waits, input logic drop_early);
        int          idx;
        int          n_access;
        logic        err_dec;
        logic        to_hit;
        logic [31:0] exp_rd;
        exp_t        e;
        idx     = b ? int'(ad[31:30]) : int'(ad[31]);
        err_dec = b && (idx == 3);
        to_hit  = 1'b0;
`ifdef BUS_TIMEOUT_EN
        to_hit  = !err_dec && (waits >= TIMEOUT_CYC);
`endif
        n_access = err_dec ? 0 : (to_hit ? TIMEOUT_CYC : waits + 1);
        for (int i = 0; i < 2; i++)
            a_srdata[i*32 +: 32] = (!b && i == idx) ? rd : (rd ^ 32'h5A5A_0000 ^ 32'(i));
        for (int i = 0; i < 3; i++)
            b_srdata[i*32 +: 32] = (b && i == idx) ? rd : (rd ^ 32'hA5A5_0000 ^ 32'(i));
        a_sready = '0;
        b_sready = '0;
        use_b = b; we = w; addr = ad; wdata = wd; req = 1'b1;
        if (err_dec || to_hit) exp_rd = 32'hDEADBEEF;
        else if (w)            exp_rd = b ? last_b : last_a;
        else                   exp_rd = rd;
        if (b) last_b = exp_rd; else last_a = exp_rd;
        e.dut = b; e.err = err_dec || to_hit; e.rdata = exp_rd; e.cyc = 32'(cyc + 1 + n_access);
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (drop_early) req = 1'b0;
        addr = ~ad; wdata = ~wd; we = ~w;
        for (int i = 0; i < n_access; i++) begin
            chk("slv_cs", b ? 32'(b_cs) : 32'(a_cs), 32'(1 << idx));
            chk("slv_we", {31'd0, (b ? b_we : a_we)}, {31'd0, w});
            chk("slv_addr", b ? b_addr : a_addr, ad);
            chk("slv_wdata", b ? b_wdata : a_wdata, wd);
            if (!to_hit && i == waits) begin
                a_sready = '1;
                b_sready = '1;
            end else begin
                a_sready = ~2'(1 << idx);
                b_sready = ~3'(1 << idx);
            end
            @(posedge clk); #1;
        end
        chk("cs_idle_in_resp", b ? 32'(b_cs) : 32'(a_cs), 32'd0);
        chk("we_idle_in_resp", {31'd0, (b ? b_we : a_we)}, 32'd0);
        a_sready = '0;
        b_sready = '0;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    initial begin
        req = 1'b0; use_b = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        a_srdata = '0; b_srdata = '0; a_sready = '0; b_sready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_cs", 32'(a_cs), 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_a_err", {31'd0, a_err}, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_a_addr", a_addr, 32'd0);
        chk("rst_a_wdata", a_wdata, 32'd0);
        chk("rst_a_we", {31'd0, a_we}, 32'd0);
        chk("rst_b_cs", 32'(b_cs), 32'd0);
        chk("rst_b_rdata", b_rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        txn(1'b0, 1'b0, 32'h0000_0010, 32'h0,      32'h0000_1000, 0, 1'b0);
        txn(1'b0, 1'b1, 32'h8000_0004, 32'hFFFF,   32'h1111_2222, 3, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        txn(1'b0, 1'b0, 32'h8000_0008, 32'h0,      32'hCAFE_F00D, 1, 1'b1);
        txn(1'b1, 1'b0, 32'hC000_0000, 32'h0,      32'h1234_5678, 0, 1'b0);
        txn(1'b1, 1'b0, 32'h8000_0000, 32'h0,      32'h0000_2222, 2, 1'b0);
        txn(1'b1, 1'b1, 32'h4000_0000, 32'h7777,   32'h9999_9999, 0, 1'b0);
        txn(1'b0, 1'b0, 32'h0000_0020, 32'h0,      32'h0000_1515, 15, 1'b0);
        txn(1'b0, 1'b0, 32'h0000_0024, 32'h0,      32'h0000_2020, 20, 1'b0);
        txn(1'b0, 1'b0, 32'h0000_0028, 32'h0,      32'h0000_4444, 0, 1'b0);
        txn(1'b0, 1'b0, 32'h8000_0084, 32'h0,      32'hB2B2_0001, 0, 1'b0);
        txn(1'b0, 1'b1, 32'h0000_0088, 32'hABCD,   32'hB2B2_0002, 2, 1'b0);
        txn(1'b0, 1'b0, 32'h8000_008C, 32'h0,      32'hB2B2_0003, 0, 1'b0);

        // Reset while the access is waiting on a slave that never answers.
        use_b = 1'b0; we = 1'b0; addr = 32'h0000_0100; req = 1'b1;
        a_sready = '0; b_sready = '0;
        @(posedge clk); #1;
        chk("pre_rst_cs", 32'(a_cs), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(a_cs), 32'd0);
        chk("mid_rst_ready", {31'd0, a_ready}, 32'd0);
        chk("mid_rst_rdata", a_rdata, 32'd0);
        req = 1'b0;
        last_a = 32'd0;
        last_b = 32'd0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 32'h0000_3000, 32'h0, 32'h0000_3000, 0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
